// File: rtl/elec_lock_ctrl.sv
// Keypad password controller for the electronic lock.
// Collects four BCD digits, checks them and times the open/error/lockout dwell.
module elec_lock_ctrl #(
  parameter logic [15:0] PASSWORD = 16'h1234,
  parameter int unsigned OPEN_CYC = 250_000_000,
  parameter int unsigned ERR_CYC  = 50_000_000,
  parameter int unsigned LOCK_CYC = 500_000_000,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] lock_state,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt,
  output logic       unlock_pulse
);

  localparam int unsigned MAX_AB =
    (OPEN_CYC > ERR_CYC) ? OPEN_CYC : ERR_CYC;
  localparam int unsigned MAX_C =
    (MAX_AB > LOCK_CYC) ? MAX_AB : LOCK_CYC;
  localparam int TW = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] ERR_LD  = TW'(ERR_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);
  localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_ERR,
    S_LOCK
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     buf_q, buf_d;
  logic [2:0]      dcnt_q, dcnt_d;
  logic            ovf_q, ovf_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      ls_q, ls_d;
  logic            pulse_q, pulse_d;

  logic            key_dig;
  logic            key_clr;
  logic            key_ent;
  logic            tmr_zero;
  logic [2:0]      fcnt_inc;

  assign key_dig  = key_valid && (key_code <= 4'd9);
  assign key_clr  = key_valid && (key_code == 4'hA);
  assign key_ent  = key_valid && (key_code == 4'hB);
  assign tmr_zero = (tmr_q == '0);
  assign fcnt_inc = fcnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    ovf_d   = ovf_q;
    fcnt_d  = fcnt_q;
    tmr_d   = tmr_q - TW'(1);
    pulse_d = 1'b0;
    ls_d    = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          key_dig: begin
            if (dcnt_q < 3'd4) begin
              buf_d  = {buf_q[11:0], key_code};
              dcnt_d = dcnt_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          key_clr: begin
            buf_d  = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
          end
          key_ent: begin
            buf_d  = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
            if (dcnt_q == 3'd4 && !ovf_q && buf_q == PASSWORD) begin
              state_d = S_OPEN;
              tmr_d   = OPEN_LD;
              fcnt_d  = '0;
              pulse_d = 1'b1;
            end else if (fcnt_inc == FAIL_MAX) begin
              state_d = S_LOCK;
              tmr_d   = LOCK_LD;
              fcnt_d  = fcnt_inc;
            end else begin
              state_d = S_ERR;
              tmr_d   = ERR_LD;
              fcnt_d  = fcnt_inc;
            end
          end
          default: ;
        endcase
      end
      S_OPEN: begin
        if (key_clr || tmr_zero) state_d = S_IDLE;
      end
      S_ERR: begin
        if (tmr_zero) state_d = S_IDLE;
      end
      S_LOCK: begin
        if (tmr_zero) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_OPEN:  ls_d = 2'd1;
      S_ERR:   ls_d = 2'd2;
      S_LOCK:  ls_d = 2'd2;
      default: ls_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      dcnt_q  <= '0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
      tmr_q   <= '0;
      ls_q    <= 2'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dcnt_q  <= dcnt_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
      tmr_q   <= tmr_d;
      ls_q    <= ls_d;
      pulse_q <= pulse_d;
    end
  end

  assign lock_state   = ls_q;
  assign digit_cnt    = dcnt_q;
  assign fail_cnt     = fcnt_q;
  assign unlock_pulse = pulse_q;

endmodule

// File: tb/tb_elec_lock_ctrl.sv
// Bench for elec_lock_ctrl: cycle model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_elec_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] lock_state;
  logic [2:0] digit_cnt;
  logic [2:0] fail_cnt;
  logic       unlock_pulse;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  elec_lock_ctrl #(
    .PASSWORD(16'h1234),
    .OPEN_CYC(20),
    .ERR_CYC (10),
    .LOCK_CYC(30),
    .MAX_FAIL(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .lock_state  (lock_state),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt),
    .unlock_pulse(unlock_pulse)
  );

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 open, 2 error, 3 lockout; rem = cycles left
  int m_mode, m_rem, m_fail;
  bit m_ovf, m_pulse, m_ok;
  int q[$];
  int pw[4] = '{1, 2, 3, 4};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_rem = 0; m_fail = 0;
      m_ovf = 0; m_pulse = 0;
      q.delete();
    end else begin
      m_pulse = 0;
      if (m_mode == 0) begin
        if (key_valid && key_code <= 4'd9) begin
          if (q.size() < 4) q.push_back(int'(key_code));
          else m_ovf = 1;
        end else if (key_valid && key_code == 4'hA) begin
          q.delete();
          m_ovf = 0;
        end else if (key_valid && key_code == 4'hB) begin
          m_ok = (q.size() == 4) && !m_ovf;
          if (m_ok)
            for (int i = 0; i < 4; i++)
              if (q[i] != pw[i]) m_ok = 0;
          if (m_ok) begin
            m_mode = 1; m_rem = 20; m_fail = 0; m_pulse = 1;
          end else begin
            m_fail++;
            if (m_fail == 3) begin m_mode = 3; m_rem = 30; end
            else begin m_mode = 2; m_rem = 10; end
          end
          q.delete();
          m_ovf = 0;
        end
      end else if (m_mode == 1 && key_valid && key_code == 4'hA) begin
        m_mode = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_mode == 3) m_fail = 0;
          m_mode = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_lock",  int'(lock_state), (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : 2);
      chk("m_digit", int'(digit_cnt), q.size());
      chk("m_fail",  int'(fail_cnt), m_fail);
      chk("m_pulse", int'(unlock_pulse), int'(m_pulse));
    end
  end

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic burst(input logic [3:0] c[5]);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_code  = c[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic keys4(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (lock_state != 2'd0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", int'(lock_state), 0);
  endtask

  logic [3:0] bb[5];

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_lock", int'(lock_state), 0);
    chk("rst_digit", int'(digit_cnt), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    chk("rst_pulse", int'(unlock_pulse), 0);
    rst_n = 1'b1;

    // correct password and 20-cycle dwell
    keys4(1, 2, 3, 4);
    chk("t1_dcnt", int'(digit_cnt), 4);
    key(4'hB);
    chk("t1_open", int'(lock_state), 1);
    chk("t1_pulse", int'(unlock_pulse), 1);
    idle(1);
    chk("t1_pulse_off", int'(unlock_pulse), 0);
    idle(18);
    chk("t1_still_open", int'(lock_state), 1);
    idle(1);
    chk("t1_relock", int'(lock_state), 0);

    // wrong password, 10-cycle error, digit ignored
    keys4(1, 2, 3, 5);
    key(4'hB);
    chk("t2_err", int'(lock_state), 2);
    chk("t2_fail", int'(fail_cnt), 1);
    key(4'h7);
    chk("t2_dig_ign", int'(digit_cnt), 0);
    idle(7);
    chk("t2_still_err", int'(lock_state), 2);
    idle(1);
    chk("t2_back", int'(lock_state), 0);

    // lockout after three failures
    pulse_rst();
    for (int k = 0; k < 2; k++) begin
      keys4(9, 9, 9, 9);
      key(4'hB);
      wait_idle(20);
    end
    chk("t3_fail2", int'(fail_cnt), 2);
    keys4(9, 9, 9, 9);
    key(4'hB);
    chk("t3_lock", int'(lock_state), 2);
    chk("t3_fail3", int'(fail_cnt), 3);
    idle(29);
    chk("t3_still_lock", int'(lock_state), 2);
    idle(1);
    chk("t3_unlock", int'(lock_state), 0);
    chk("t3_fail0", int'(fail_cnt), 0);
    keys4(1, 2, 3, 4);
    key(4'hB);
    chk("t3_open", int'(lock_state), 1);
    wait_idle(30);

    // entry errors
    pulse_rst();
    key(1); key(2); key(3);
    key(4'hB);
    chk("t4_short", int'(lock_state), 2);
    wait_idle(20);
    keys4(1, 2, 3, 4);
    key(5);
    chk("t4_ovf_dcnt", int'(digit_cnt), 4);
    key(4'hB);
    chk("t4_ovf", int'(lock_state), 2);
    chk("t4_ovf_fail", int'(fail_cnt), 2);
    wait_idle(20);
    key(9); key(9); key(4'hA);
    chk("t4_clr", int'(digit_cnt), 0);
    keys4(1, 2, 3, 4);
    key(4'hB);
    chk("t4_clr_open", int'(lock_state), 1);
    chk("t4_fail0", int'(fail_cnt), 0);
    wait_idle(30);

    // early relock, clear on expiry cycle, failure reset
    keys4(1, 2, 3, 4);
    key(4'hB);
    idle(3);
    key(4'hA);
    chk("t5_early", int'(lock_state), 0);
    keys4(1, 2, 3, 4);
    key(4'hB);
    idle(18);
    key(4'hA);
    chk("t5_clr_exp", int'(lock_state), 0);
    keys4(1, 2, 3, 6);
    key(4'hB);
    chk("t5_fail1", int'(fail_cnt), 1);
    wait_idle(20);
    keys4(1, 2, 3, 4);
    key(4'hB);
    chk("t5_fail_clr", int'(fail_cnt), 0);
    wait_idle(30);

    // reset mid-lockout, back-to-back strobes, no-op code
    pulse_rst();
    for (int k = 0; k < 3; k++) begin
      keys4(8, 8, 8, 8);
      key(4'hB);
      if (k < 2) wait_idle(20);
    end
    idle(10);
    chk("t6_in_lock", int'(lock_state), 2);
    pulse_rst();
    chk("t6_rst_lock", int'(lock_state), 0);
    chk("t6_rst_fail", int'(fail_cnt), 0);
    chk("t6_rst_dcnt", int'(digit_cnt), 0);
    bb = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB};
    burst(bb);
    chk("t6_b2b", int'(lock_state), 1);
    wait_idle(30);
    key(1);
    key(4'hE);
    chk("t6_noop", int'(digit_cnt), 1);
    chk("t6_noop_st", int'(lock_state), 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
